spi_rom_subsystem: RTL and testbench
====================================

// Module: spi_rom_subsystem
// PURPOSE
//  SPI subsystem: one master (master_device) and NUM_SLAVES read-only slaves (slave_device),
//  all on one CLK. Given a slave select (SS_ADDR) and a register address (DATA_ADDR), the
//  master reads one byte from that slave's fixed 8-entry ROM and presents it on DATA.
//  Bus signals are exported for observation. Slave MISO outputs are OR-combined onto MISO.
// PARAMETERS
//  NUM_SLAVES  4  slave count; SS width; SS_ADDR width = clog2(NUM_SLAVES)
//  HALF_SCLK   2  CLK cycles per SCLK half-period; minimum 2
// PORTS
//  CLK        in   1  system clock; every flop is clocked by its rising edge
//  RST_N      in   1  asynchronous, active-low reset
//  SS_ADDR    in   2  index of the target slave
//  DATA_ADDR  in   8  ROM address sent to the slave
//  DATA       out  8  last byte read; holds until the next read completes
//  DONE       out  1  1-cycle pulse when DATA updates
//  BUSY       out  1  high while a transaction is in progress
//  SCLK       out  1  SPI clock, idles low (mode 0)
//  MOSI       out  1  master -> slave serial data
//  MISO       out  1  OR of all slave MISO outputs
//  SS         out  4  slave selects, active-low, one-hot-low while BUSY
// BEHAVIOUR
//  Reset: SCLK=0, MOSI=0, SS=4'hF, DATA=0, DONE=0, BUSY=0, FSM=IDLE.
//  Reset: slave shift registers and counters clear; slave MISO=0.
//  Reset also clears the "last served" request register.
//  Transaction start: the master starts a transaction when it is in IDLE and either
//   - {SS_ADDR,DATA_ADDR} differs from the last served pair, or
//   - it is the first IDLE cycle after reset.
//  On start the master latches SS_ADDR and DATA_ADDR.
//  Inputs that change mid-transaction are ignored. Once the master returns to IDLE,
//   the new value starts a new transaction.
//  Master FSM states:
//   IDLE  -> SETUP on start.
//   SETUP: SS[sel]=0, MOSI=addr[7]; lasts HALF_SCLK cycles.
//   SHIFT: 16 SCLK periods (8 address bits, then 8 data bits), MSB first.
//     - SCLK goes high for HALF_SCLK cycles, then low for HALF_SCLK cycles.
//     - MOSI changes only on the CLK cycle SCLK goes low.
//     - In the data phase MOSI=0.
//     - The master samples MISO on the last CLK cycle of each high phase in bits 9..16.
//   HOLD: SCLK=0 for HALF_SCLK cycles, then SS=4'hF.
//     - DATA <= sampled byte, DONE=1 for one cycle.
//     - The pair is recorded as last served. Next state is IDLE.
//  Latency: start to DONE = 1 + HALF_SCLK*(2+32) cycles (69 at default).
//  Slave (one per SS bit, identical ROMs):
//   - Detects SCLK edges in the CLK domain using a registered SCLK copy.
//   - SS high: bit counter=0, MISO=0.
//   - SS low: on each detected rise of bits 1..8, shift MOSI in.
//   - After the 8th rise, load ROM[addr] and drive its bit 7.
//   - On each detected fall in the data phase, advance to the next bit.
//   - MISO=0 outside the data phase.
//  ROM contents (all other addresses return 8'h00):
//   1A->41  1B->DC  1C->3B  1D->4E  2A->8C  2B->B5  2C->05  2D->E5
//  Deselected slaves drive 0, so the OR on MISO is always valid.
//  Reset mid-transaction: aborts immediately to the reset values; after release a
//   transaction for the current inputs starts.
// TESTING
//  1. Reset, then hold SS_ADDR=0, DATA_ADDR=1A.
//     -> SS=4'hE during the transfer; DONE after 69 cycles; DATA=41.
//  2. Sweep SS_ADDR 0..3 x addresses {1A,1B,1C,1D,2A,2B,2C,2D}, waiting 80 cycles each.
//     -> DATA = 41,DC,3B,4E,8C,B5,05,E5 for every slave; 32/32 pass.
//     -> Only SS[SS_ADDR] goes low in each transfer.
//  3. SS_ADDR=2, DATA_ADDR=55 (unmapped).
//     -> DATA=00.
//     -> MOSI shows 0,1,0,1,0,1,0,1 on SCLK rises.
//  4. Change DATA_ADDR from 1B to 2D at cycle 20 of a transaction.
//     -> First DONE gives DC; a second transaction follows and gives E5.
//  5. Hold the inputs constant after DONE.
//     -> No further transactions; SCLK stays 0; BUSY=0.
//  6. Assert RST_N low mid-SHIFT.
//     -> SS=F, SCLK=0, DATA=0 at once.
//     -> After release, the read completes correctly.

Source files
------------

// File: rtl/spi_rom_subsystem.sv
// rtl/spi_rom_subsystem.sv - SPI master reading one byte from one of NUM_SLAVES ROM slaves
module spi_rom_subsystem #(
  parameter int NUM_SLAVES = 4,
  parameter int HALF_SCLK  = 2,
  localparam int SSW = $clog2(NUM_SLAVES)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [SSW-1:0]        SS_ADDR,
  input  logic [7:0]            DATA_ADDR,
  output logic [7:0]            DATA,
  output logic                  DONE,
  output logic                  BUSY,
  output logic                  SCLK,
  output logic                  MOSI,
  output logic                  MISO,
  output logic [NUM_SLAVES-1:0] SS
);
  localparam int CW = (HALF_SCLK > 1) ? $clog2(HALF_SCLK) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HALF_SCLK - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [4:0]            r_phase, w_phase_nxt;
  logic                  r_sclk, w_sclk_nxt;
  logic                  r_mosi, w_mosi_nxt;
  logic [NUM_SLAVES-1:0] r_ss, w_ss_nxt;
  logic [7:0]            r_data, w_data_nxt;
  logic [7:0]            r_rx, w_rx_nxt;
  logic [7:0]            r_addr, w_addr_nxt;
  logic                  r_done, w_done_nxt;
  logic [SSW-1:0]        r_sel, w_sel_nxt;
  logic [SSW+7:0]        r_last, w_last_nxt;
  logic                  r_first, w_first_nxt;
  logic                  w_start, w_half_end;
  logic [NUM_SLAVES-1:0] w_miso;

  function automatic logic [7:0] rom_lookup(input logic [7:0] a);
    case (a)
      8'h1A: rom_lookup = 8'h41;
      8'h1B: rom_lookup = 8'hDC;
      8'h1C: rom_lookup = 8'h3B;
      8'h1D: rom_lookup = 8'h4E;
      8'h2A: rom_lookup = 8'h8C;
      8'h2B: rom_lookup = 8'hB5;
      8'h2C: rom_lookup = 8'h05;
      8'h2D: rom_lookup = 8'hE5;
      default: rom_lookup = 8'h00;
    endcase
  endfunction

  // r_first forces one read after reset even if the inputs match the cleared r_last
  assign w_start    = (r_state == S_IDLE) && (r_first || ({SS_ADDR, DATA_ADDR} != r_last));
  assign w_half_end = (r_cnt == CNT_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_sclk_nxt  = r_sclk;
    w_mosi_nxt  = r_mosi;
    w_ss_nxt    = r_ss;
    w_data_nxt  = r_data;
    w_rx_nxt    = r_rx;
    w_addr_nxt  = r_addr;
    w_done_nxt  = 1'b0;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_first_nxt = r_first;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt        = S_SETUP;
          w_sel_nxt          = SS_ADDR;
          w_addr_nxt         = DATA_ADDR;
          w_first_nxt        = 1'b0;
          w_cnt_nxt          = '0;
          w_ss_nxt           = '1;
          w_ss_nxt[SS_ADDR]  = 1'b0;
          w_mosi_nxt         = DATA_ADDR[7];
        end
      end
      S_SETUP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_half_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
          w_sclk_nxt  = 1'b1;
          w_phase_nxt = '0;
        end
      end
      S_SHIFT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_half_end) begin
          w_cnt_nxt   = '0;
          w_phase_nxt = r_phase + 5'd1;
          if (!r_phase[0]) begin
            // end of a high half: falling edge, next MOSI bit, sample in data phase
            w_sclk_nxt = 1'b0;
            if (!r_phase[4] && (r_phase[3:1] != 3'd7))
              w_mosi_nxt = r_addr[3'd6 - r_phase[3:1]];
            else
              w_mosi_nxt = 1'b0;
            if (r_phase[4])
              w_rx_nxt = {r_rx[6:0], MISO};
          end else if (r_phase == 5'd31) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_sclk_nxt = 1'b1;
          end
        end
      end
      S_HOLD: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_half_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          w_ss_nxt    = '1;
          w_mosi_nxt  = 1'b0;
          w_data_nxt  = r_rx;
          w_done_nxt  = 1'b1;
          w_last_nxt  = {r_sel, r_addr};
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_phase <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_ss    <= '1;
      r_data  <= '0;
      r_rx    <= '0;
      r_addr  <= '0;
      r_done  <= 1'b0;
      r_sel   <= '0;
      r_last  <= '0;
      r_first <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      r_sclk  <= w_sclk_nxt;
      r_mosi  <= w_mosi_nxt;
      r_ss    <= w_ss_nxt;
      r_data  <= w_data_nxt;
      r_rx    <= w_rx_nxt;
      r_addr  <= w_addr_nxt;
      r_done  <= w_done_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_first <= w_first_nxt;
    end
  end

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave
    logic       r_sclk_q;
    logic [4:0] r_bcnt;
    logic [7:0] r_sr;
    logic       r_miso;
    logic       w_rise, w_fall;
    logic [7:0] w_rom;

    assign w_rise = r_sclk && !r_sclk_q;
    assign w_fall = !r_sclk && r_sclk_q;
    assign w_rom  = rom_lookup({r_sr[6:0], r_mosi});

    // r_bcnt counts detected rises; the fall after rise 8 is skipped so ROM bit 7 survives
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_sclk_q <= 1'b0;
        r_bcnt   <= '0;
        r_sr     <= '0;
        r_miso   <= 1'b0;
      end else begin
        r_sclk_q <= r_sclk;
        if (r_ss[g]) begin
          r_bcnt <= '0;
          r_sr   <= '0;
          r_miso <= 1'b0;
        end else if (w_rise) begin
          if (r_bcnt < 5'd7) begin
            r_sr <= {r_sr[6:0], r_mosi};
          end else if (r_bcnt == 5'd7) begin
            r_sr   <= w_rom;
            r_miso <= w_rom[7];
          end
          if (r_bcnt != 5'd16)
            r_bcnt <= r_bcnt + 5'd1;
        end else if (w_fall && (r_bcnt >= 5'd9)) begin
          r_sr   <= {r_sr[6:0], 1'b0};
          r_miso <= (r_bcnt == 5'd16) ? 1'b0 : r_sr[6];
        end
      end
    end

    assign w_miso[g] = r_miso;
  end

  assign MISO = |w_miso;
  assign DATA = r_data;
  assign DONE = r_done;
  assign BUSY = (r_state != S_IDLE);
  assign SCLK = r_sclk;
  assign MOSI = r_mosi;
  assign SS   = r_ss;

endmodule

// File: tb/tb_spi_rom_subsystem.sv
// tb/tb_spi_rom_subsystem.sv - table-driven bench for spi_rom_subsystem
module tb_spi_rom_subsystem;
  logic       CLK = 1'b0;
  logic       RST_N;
  logic [1:0] SS_ADDR;
  logic [7:0] DATA_ADDR;
  logic [7:0] DATA;
  logic       DONE, BUSY, SCLK, MOSI, MISO;
  logic [3:0] SS;

  spi_rom_subsystem #(.NUM_SLAVES(4), .HALF_SCLK(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .SS_ADDR(SS_ADDR), .DATA_ADDR(DATA_ADDR),
    .DATA(DATA), .DONE(DONE), .BUSY(BUSY), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .SS(SS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[33];
  logic [7:0] addr_tab[8] = '{8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h2A, 8'h2B, 8'h2C, 8'h2D};
  logic [7:0] data_tab[8] = '{8'h41, 8'hDC, 8'h3B, 8'h4E, 8'h8C, 8'hB5, 8'h05, 8'hE5};

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] g_mosi;
  int          g_rises;
  bit          g_ss_bad, g_ss_low;
  int          g_cycles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for DONE (bounded), recording MOSI at each SCLK rise and every SS value seen
  task automatic wait_done(input logic [3:0] exp_ss);
    logic prev;
    prev     = SCLK;
    g_cycles = 0;
    g_rises  = 0;
    g_mosi   = '0;
    g_ss_bad = 0;
    g_ss_low = 0;
    while (g_cycles < 200) begin
      @(negedge CLK);
      g_cycles++;
      if (SCLK && !prev) begin
        if (g_rises < 16) g_mosi[15 - g_rises] = MOSI;
        g_rises++;
      end
      prev = SCLK;
      if (SS != 4'hF) begin
        g_ss_low = 1;
        if (SS != exp_ss) g_ss_bad = 1;
      end
      if (DONE) break;
    end
    check("done_seen", DONE, 1'b1);
  endtask

  task automatic check_full(input string tag, input logic [1:0] sel, input logic [7:0] addr,
                            input logic [7:0] exp);
    check({tag, "_latency"}, g_cycles, 69);
    check({tag, "_data"}, DATA, exp);
    check({tag, "_mosi"}, g_mosi, {addr, 8'h00});
    check({tag, "_rises"}, g_rises, 16);
    check({tag, "_ss_other"}, g_ss_bad, 1'b0);
    check({tag, "_ss_low"}, g_ss_low, 1'b1);
    check({tag, "_ss_sel"}, sel, sel);
  endtask

  initial begin
    int         viol;
    logic [3:0] ess;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 8; a++) begin
        vecs[s*8 + a].sel  = 2'(3 - s);
        vecs[s*8 + a].addr = addr_tab[a];
        vecs[s*8 + a].exp  = data_tab[a];
      end
    vecs[32].sel  = 2'd2;
    vecs[32].addr = 8'h55;
    vecs[32].exp  = 8'h00;

    // Reset state
    RST_N     = 1'b0;
    SS_ADDR   = 2'd0;
    DATA_ADDR = 8'h1A;
    repeat (3) @(negedge CLK);
    check("rst_ss", SS, 4'hF);
    check("rst_sclk", SCLK, 1'b0);
    check("rst_mosi", MOSI, 1'b0);
    check("rst_data", DATA, 8'h00);
    check("rst_done", DONE, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_miso", MISO, 1'b0);

    // First read right after reset release
    RST_N = 1'b1;
    wait_done(4'hE);
    check_full("t1", 2'd0, 8'h1A, 8'h41);

    // Sweep of all slaves and mapped addresses, then unmapped 55
    for (int i = 0; i < 33; i++) begin
      SS_ADDR   = vecs[i].sel;
      DATA_ADDR = vecs[i].addr;
      ess       = 4'hF;
      ess[vecs[i].sel] = 1'b0;
      wait_done(ess);
      check_full($sformatf("v%0d", i), vecs[i].sel, vecs[i].addr, vecs[i].exp);
    end

    // Input change mid-transaction is ignored, then served next
    SS_ADDR   = 2'd1;
    DATA_ADDR = 8'h1B;
    repeat (20) @(negedge CLK);
    check("t4_busy", BUSY, 1'b1);
    DATA_ADDR = 8'h2D;
    wait_done(4'hD);
    check("t4a_latency", g_cycles + 20, 69);
    check("t4a_data", DATA, 8'hDC);
    check("t4a_ss_other", g_ss_bad, 1'b0);
    wait_done(4'hD);
    check_full("t4b", 2'd1, 8'h2D, 8'hE5);

    // Constant inputs: no further transactions
    viol = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (BUSY || SCLK || DONE || SS != 4'hF) viol++;
    end
    check("t5_idle_viol", viol, 0);
    check("t5_data_hold", DATA, 8'hE5);

    // Reset in the middle of SHIFT
    SS_ADDR   = 2'd3;
    DATA_ADDR = 8'h2C;
    repeat (30) @(negedge CLK);
    check("t6_busy_pre", BUSY, 1'b1);
    RST_N = 1'b0;
    #1;
    check("t6_ss", SS, 4'hF);
    check("t6_sclk", SCLK, 1'b0);
    check("t6_data", DATA, 8'h00);
    check("t6_busy", BUSY, 1'b0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    wait_done(4'h7);
    check_full("t6", 2'd3, 8'h2C, 8'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
